// File: rtl/mux_scan_sel.sv
// mux_scan_sel: registered N-channel selector.
// Each cycle one of n_ch data words is chosen under one of four modes:
// direct select, timed round-robin scan, fixed priority (lowest index wins)
// or maximum value (ties to the lowest index). The chosen word, its channel
// index and a valid flag are all registered, so there is no combinational
// path from any input to any output. 'hold' freezes the outputs and the
// scan state; the previous-mode register keeps tracking 'mode' regardless,
// so that scan entry is detected against the real mode history.
module mux_scan_sel #(
    parameter int n_ch     = 4,
    parameter int w_data   = 8,
    parameter int w_sel    = $clog2(n_ch),
    parameter int w_period = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [n_ch*w_data-1:0]   data,
    input  logic [n_ch-1:0]          ch_en,
    input  logic [1:0]               mode,
    input  logic [w_sel-1:0]         sel,
    input  logic [w_period-1:0]      period,
    input  logic                     hold,
    output logic [w_data-1:0]        out,
    output logic [w_sel-1:0]         out_ch,
    output logic                     out_valid
);

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_SCAN   = 2'b01;
    localparam logic [1:0] MODE_PRIO   = 2'b10;
    localparam logic [1:0] MODE_MAX    = 2'b11;

    // Channel count widened by one bit so an out-of-range 'sel' can be
    // detected when n_ch is not a power of two.
    localparam logic [w_sel:0] LP_N_CH = (w_sel+1)'(n_ch);

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Word of channel 'idx'; indices beyond n_ch yield zero.
    function automatic logic [w_data-1:0] f_word(
        input logic [n_ch*w_data-1:0] d,
        input logic [w_sel-1:0]       idx
    );
        logic [w_data-1:0] word;
        word = '0;
        for (int i = 0; i < n_ch; i++) begin
            if (w_sel'(i) == idx) begin
                word = d[i*w_data +: w_data];
            end else begin
                word = word;
            end
        end
        return word;
    endfunction

    // Enable bit of channel 'idx'; indices beyond n_ch read as disabled.
    function automatic logic f_en_bit(
        input logic [n_ch-1:0]  en,
        input logic [w_sel-1:0] idx
    );
        logic bit_v;
        bit_v = 1'b0;
        for (int i = 0; i < n_ch; i++) begin
            if (w_sel'(i) == idx) begin
                bit_v = en[i];
            end else begin
                bit_v = bit_v;
            end
        end
        return bit_v;
    endfunction

    // Lowest enabled channel index (zero when none is enabled).
    function automatic logic [w_sel-1:0] f_lowest(
        input logic [n_ch-1:0] en
    );
        logic [w_sel-1:0] idx;
        idx = '0;
        // Scan downwards so the last hit is the lowest index.
        for (int i = n_ch - 1; i >= 0; i--) begin
            if (en[i]) begin
                idx = w_sel'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Next enabled channel strictly above 'p', wrapping to the lowest
    // enabled channel (which may be 'p' itself when it is the only one).
    function automatic logic [w_sel-1:0] f_next_above(
        input logic [n_ch-1:0]  en,
        input logic [w_sel-1:0] p
    );
        logic [w_sel-1:0] idx;
        idx = f_lowest(en);
        for (int i = n_ch - 1; i >= 0; i--) begin
            if (en[i] && (w_sel'(i) > p)) begin
                idx = w_sel'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Enabled channel with the largest unsigned word; ties keep the lower
    // index because only a strictly larger word replaces the candidate.
    function automatic logic [w_sel-1:0] f_max_idx(
        input logic [n_ch*w_data-1:0] d,
        input logic [n_ch-1:0]        en
    );
        logic [w_sel-1:0]  best_idx;
        logic [w_data-1:0] best_val;
        logic              found;
        best_idx = '0;
        best_val = '0;
        found    = 1'b0;
        for (int i = 0; i < n_ch; i++) begin
            if (en[i] && (!found || (d[i*w_data +: w_data] > best_val))) begin
                best_idx = w_sel'(i);
                best_val = d[i*w_data +: w_data];
                found    = 1'b1;
            end else begin
                best_idx = best_idx;
            end
        end
        return best_idx;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [w_data-1:0]   r_out;
    logic [w_sel-1:0]    r_out_ch;
    logic                r_out_valid;
    logic [w_sel-1:0]    r_ptr;
    logic [w_period-1:0] r_dwell;
    logic [1:0]          r_prev_mode;

    logic [w_data-1:0]   w_out_nxt;
    logic [w_sel-1:0]    w_out_ch_nxt;
    logic                w_out_valid_nxt;
    logic [w_sel-1:0]    w_ptr_nxt;
    logic [w_period-1:0] w_dwell_nxt;

    logic                w_any_en;
    logic                w_sel_ok;
    logic                w_cur_en;
    logic [w_sel-1:0]    w_lowest;
    logic [w_sel-1:0]    w_next;
    logic [w_sel-1:0]    w_max_idx;

    // Shared selection terms used by the next-state logic.
    always_comb begin
        w_any_en  = |ch_en;
        w_sel_ok  = ({1'b0, sel} < LP_N_CH);
        w_cur_en  = f_en_bit(ch_en, r_ptr);
        w_lowest  = f_lowest(ch_en);
        w_next    = f_next_above(ch_en, r_ptr);
        w_max_idx = f_max_idx(data, ch_en);
    end

    // Next-state selection for outputs and scan state, per mode.
    always_comb begin
        w_out_nxt       = r_out;
        w_out_ch_nxt    = r_out_ch;
        w_out_valid_nxt = r_out_valid;
        w_ptr_nxt       = r_ptr;
        w_dwell_nxt     = r_dwell;

        if (hold) begin
            // Everything keeps its value; defaults above already say so.
            w_out_valid_nxt = r_out_valid;
        end else begin
            case (mode)
                MODE_DIRECT: begin
                    if (w_sel_ok) begin
                        w_out_nxt       = f_word(data, sel);
                        w_out_ch_nxt    = sel;
                        w_out_valid_nxt = 1'b1;
                    end else begin
                        w_out_valid_nxt = 1'b0;
                    end
                end

                MODE_SCAN: begin
                    if (r_prev_mode != MODE_SCAN) begin
                        // Entry restarts at the lowest enabled channel; it
                        // outranks any pending dwell expiry.
                        if (w_any_en) begin
                            w_ptr_nxt = w_lowest;
                        end else begin
                            w_ptr_nxt = r_ptr;
                        end
                        w_dwell_nxt     = '0;
                        w_out_valid_nxt = w_any_en;
                    end else if (!w_any_en) begin
                        // Nothing to show: pointer and dwell stay frozen.
                        w_out_valid_nxt = 1'b0;
                    end else if (!w_cur_en) begin
                        // Current channel dropped out mid-dwell: move on and
                        // flag the cycle it would have been shown as invalid.
                        w_ptr_nxt       = w_next;
                        w_dwell_nxt     = '0;
                        w_out_valid_nxt = 1'b0;
                    end else if (r_dwell >= period) begin
                        // '>=' so a shortened period forces an advance.
                        w_ptr_nxt       = w_next;
                        w_dwell_nxt     = '0;
                        w_out_valid_nxt = 1'b1;
                    end else begin
                        w_dwell_nxt     = r_dwell + w_period'(1);
                        w_out_valid_nxt = 1'b1;
                    end
                    w_out_nxt    = f_word(data, w_ptr_nxt);
                    w_out_ch_nxt = w_ptr_nxt;
                end

                MODE_PRIO: begin
                    if (w_any_en) begin
                        w_out_nxt       = f_word(data, w_lowest);
                        w_out_ch_nxt    = w_lowest;
                        w_out_valid_nxt = 1'b1;
                    end else begin
                        w_out_valid_nxt = 1'b0;
                    end
                end

                MODE_MAX: begin
                    if (w_any_en) begin
                        w_out_nxt       = f_word(data, w_max_idx);
                        w_out_ch_nxt    = w_max_idx;
                        w_out_valid_nxt = 1'b1;
                    end else begin
                        w_out_valid_nxt = 1'b0;
                    end
                end

                default: begin
                    w_out_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; prev_mode follows 'mode' even during hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out       <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= '0;
            r_dwell     <= '0;
            r_prev_mode <= MODE_DIRECT;
        end else begin
            r_out       <= w_out_nxt;
            r_out_ch    <= w_out_ch_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_ptr       <= w_ptr_nxt;
            r_dwell     <= w_dwell_nxt;
            r_prev_mode <= mode;
        end
    end

    assign out       = r_out;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

endmodule
